// File: rtl/cla_nibble_sequencer_if.sv
// -----------------------------------------------------------------------------
// cla_nibble_sequencer_if
//
// Request/result bus between a requesting datapath and cla_nibble_sequencer.
//
// Handshake: the requester raises start with a_in/b_in/cin_in (and sub when
// CLA_NIBBLE_SEQUENCER_SUB_EN is defined) valid on the same edge. The request
// is taken only while the sequencer is idle (busy=0, done=0); start at any
// other time is dropped, not queued. done is a one-cycle pulse marking
// sum_out/cout_out/ovf_out valid; those results hold until the next accepted
// start.
//
// Signals:
//   start    requester -> sequencer  request strobe
//   a_in     requester -> sequencer  operand A (WIDTH)
//   b_in     requester -> sequencer  operand B (WIDTH)
//   cin_in   requester -> sequencer  initial carry-in
//   sub      requester -> sequencer  subtract select (CLA_NIBBLE_SEQUENCER_SUB_EN only)
//   busy     sequencer -> requester  high while nibbles are being processed
//   done     sequencer -> requester  one-cycle result-valid pulse
//   sum_out  sequencer -> requester  result (WIDTH)
//   cout_out sequencer -> requester  final carry-out (1 = no borrow when subtracting)
//   ovf_out  sequencer -> requester  signed overflow
// -----------------------------------------------------------------------------
interface cla_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
`ifdef CLA_NIBBLE_SEQUENCER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
    logic             ovf_out;

`ifdef CLA_NIBBLE_SEQUENCER_SUB_EN
    modport master (
        output start, a_in, b_in, cin_in, sub,
        input  busy, done, sum_out, cout_out, ovf_out
    );
    modport slave (
        input  start, a_in, b_in, cin_in, sub,
        output busy, done, sum_out, cout_out, ovf_out
    );
`else
    modport master (
        output start, a_in, b_in, cin_in,
        input  busy, done, sum_out, cout_out, ovf_out
    );
    modport slave (
        input  start, a_in, b_in, cin_in,
        output busy, done, sum_out, cout_out, ovf_out
    );
`endif
endinterface

// File: rtl/cla_nibble_sequencer.sv
// -----------------------------------------------------------------------------
// cla_nibble_sequencer
//
// Adds two WIDTH-bit operands by time-sharing one external combinational 4-bit
// carry-lookahead slice, one nibble per clock, LSB nibble first. The slice
// carry-out is kept in a register and fed back as the next nibble's carry-in,
// so a full-width ripple costs no extra cycles. Result, carry-out and signed
// overflow are registered and held until the next accepted request.
//
// Optional feature (macro CLA_NIBBLE_SEQUENCER_SUB_EN): adds bus.sub; when set,
// B is inverted and the initial carry forced to 1, giving a_in - b_in.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (aborts any operation, no done)
//   bus        request/result interface (slave modport)
//   cla_a      slice operand A nibble (0 outside RUN)
//   cla_b      slice operand B nibble (0 outside RUN)
//   cla_cin    slice carry-in (0 outside RUN)
//   cla_s      slice sum nibble
//   cla_cout   slice carry-out
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// WIDTH must be a multiple of 4 and at least 4.
// -----------------------------------------------------------------------------
module cla_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    cla_nibble_sequencer_if.slave      bus,
    output logic [3:0]                 cla_a,
    output logic [3:0]                 cla_b,
    output logic                       cla_cin,
    input  logic [3:0]                 cla_s,
    input  logic                       cla_cout,
    output logic [1:0]                 dbg_state
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             sub_sel;
    logic             last;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;

`ifdef CLA_NIBBLE_SEQUENCER_SUB_EN
    assign sub_sel = bus.sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign last         = (idx == IDX_W'(NIBBLES - 1));
    assign dbg_state    = state;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum_out  = sum_q;
    assign bus.cout_out = cout_q;
    assign bus.ovf_out  = ovf_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Nibble select with constant indices; slice inputs are parked at zero
    // outside RUN so the shared slice does not toggle.
    always_comb begin
        a_nib   = '0;
        b_nib   = '0;
        cla_a   = '0;
        cla_b   = '0;
        cla_cin = 1'b0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                a_nib = a_reg[4*i +: 4];
                b_nib = b_reg[4*i +: 4];
            end
        end
        if (state == RUN) begin
            cla_a   = a_nib;
            cla_b   = b_nib;
            cla_cin = carry;
        end
    end

    // Datapath. busy/done are registered from the next state so they line up
    // exactly with RUN and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nx == RUN);
            done_q <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.a_in;
                        // b_reg holds the effective B, so overflow below
                        // needs no knowledge of the operation.
                        b_reg <= sub_sel ? ~bus.b_in : bus.b_in;
                        carry <= sub_sel ? 1'b1 : bus.cin_in;
                        sum_q <= '0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            sum_q[4*i +: 4] <= cla_s;
                        end
                    end
                    carry <= cla_cout;
                    if (last) begin
                        idx    <= '0;
                        cout_q <= cla_cout;
                        ovf_q  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                  (cla_s[3] != a_reg[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cla_nibble_sequencer
//
// Bench for cla_nibble_sequencer at WIDTH=16. A behavioural 4-bit adder stands
// in for the shared CLA slice. Expected results are queued when a request is
// driven and popped when done pulses.
// -----------------------------------------------------------------------------
module tb_cla_nibble_sequencer;
    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

    logic [3:0] cla_a, cla_b, cla_s;
    logic       cla_cin, cla_cout;
    logic [1:0] dbg_state;

    // External slice model
    assign {cla_cout, cla_s} = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};

    cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cla_a     (cla_a),
        .cla_b     (cla_b),
        .cla_cin   (cla_cin),
        .cla_s     (cla_s),
        .cla_cout  (cla_cout),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q[$];   // {cout, ovf, sum}
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] be;
        logic        c;
        logic [16:0] r;
        logic        v;
        be = sub ? ~b : b;
        c  = sub ? 1'b1 : cin;
        r  = {1'b0, a} + {1'b0, be} + {16'b0, c};
        v  = (a[15] == be[15]) && (r[15] != a[15]);
        return {r[16], v, r[15:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic sub);
        bus.start  = 1'b1;
        bus.a_in   = a;
        bus.b_in   = b;
        bus.cin_in = cin;
`ifdef CLA_NIBBLE_SEQUENCER_SUB_EN
        bus.sub    = sub;
`else
        if (sub) $display("note: subtract request dropped in add-only build");
`endif
    endtask

    task automatic release_req();
        bus.start  = 1'b0;
        bus.a_in   = 16'($urandom);
        bus.b_in   = 16'($urandom);
        bus.cin_in = 1'($urandom_range(0, 1));
    endtask

    task automatic compare_result(input string name);
        logic [17:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s/queue: got done with empty queue, want queued result", name);
            return;
        end
        e = exp_q.pop_front();
        check({name, "/sum"},  32'(bus.sum_out),  32'(e[15:0]));
        check({name, "/cout"}, 32'(bus.cout_out), 32'(e[17]));
        check({name, "/ovf"},  32'(bus.ovf_out),  32'(e[16]));
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [17:0] exp, input string name);
        int edges;
        int busy_cnt;
        logic [15:0] held;
        @(negedge clk);
        drive_req(a, b, cin, sub);
        exp_q.push_back(exp);
        @(negedge clk);
        release_req();
        edges = 0;
        busy_cnt = 0;
        while (!bus.done && edges < 40) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            edges++;
        end
        if (!bus.done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s/timeout: got no done in %0d cycles, want done", name, edges);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        check({name, "/latency"}, 32'(edges), 32'(NIBBLES));
        check({name, "/busy_cycles"}, 32'(busy_cnt), 32'(NIBBLES));
        check({name, "/busy_at_done"}, 32'(bus.busy), 32'd0);
        held = bus.sum_out;
        compare_result(name);
        @(negedge clk);
        check({name, "/done_pulse"}, 32'(bus.done), 32'd0);
        check({name, "/sum_hold"}, 32'(bus.sum_out), 32'(held));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main test ----------------
    initial begin
        int done_cnt;
        logic [15:0] ra, rb;
        logic rc;

        bus.start  = 1'b0;
        bus.a_in   = '0;
        bus.b_in   = '0;
        bus.cin_in = 1'b0;
`ifdef CLA_NIBBLE_SEQUENCER_SUB_EN
        bus.sub    = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("reset/busy",  32'(bus.busy),     32'd0);
        check("reset/done",  32'(bus.done),     32'd0);
        check("reset/sum",   32'(bus.sum_out),  32'd0);
        check("reset/cout",  32'(bus.cout_out), 32'd0);
        check("reset/ovf",   32'(bus.ovf_out),  32'd0);
        check("reset/state", 32'(dbg_state),    32'd0);
        check("reset/cla_a", 32'(cla_a),        32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic"});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_chain"});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf"});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf"});
        vecs.push_back('{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, "cin_ripple"});
`ifdef CLA_NIBBLE_SEQUENCER_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow"});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   {vecs[i].cout, vecs[i].ovf, vecs[i].sum}, vecs[i].name);
        end

        // Random additions checked against the reference model
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0), $sformatf("rand%0d", i));
        end

        // Second start while running is ignored
        @(negedge clk);
        drive_req(16'h0001, 16'h0001, 1'b0, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 16'h0002});
        @(negedge clk);
        release_req();
        @(negedge clk);
        drive_req(16'hAAAA, 16'hAAAA, 1'b1, 1'b0);
        @(negedge clk);
        release_req();
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                done_cnt++;
                compare_result("ignore_start");
            end
            @(negedge clk);
        end
        check("ignore_start/done_count", 32'(done_cnt), 32'd1);
        check("idle/cla_a",   32'(cla_a),     32'd0);
        check("idle/cla_b",   32'(cla_b),     32'd0);
        check("idle/cla_cin", 32'(cla_cin),   32'd0);
        check("idle/state",   32'(dbg_state), 32'd0);

        // Reset mid-operation aborts without done
        @(negedge clk);
        drive_req(16'h00FF, 16'h0001, 1'b0, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 16'h0100});
        @(negedge clk);
        release_req();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort/busy",  32'(bus.busy),    32'd0);
        check("abort/done",  32'(bus.done),    32'd0);
        check("abort/sum",   32'(bus.sum_out), 32'd0);
        check("abort/state", 32'(dbg_state),   32'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort/no_done", 32'(done_cnt), 32'd0);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100}, "after_abort");

        check("scoreboard/empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cla_nibble_sequencer.md
Name: cla_nibble_sequencer

Overview:
- Multi-cycle controller that time-shares one external 4-bit carry-lookahead adder slice to add WIDTH-bit operands, one nibble per clock, LSB nibble first.
- Latches operands on a start/done handshake and chains the slice carry-out into the next nibble's carry-in.
- Accumulates the sum, carry-out and signed overflow.
- Sits between a requesting datapath and a single shared 4-bit CLA instance.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived localparam: number of slice passes.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A; latched when start is accepted
- b_in  input  WIDTH  operand B; latched when start is accepted
- cin_in  input  1  initial carry-in; latched when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- sum_out  output  WIDTH  registered sum, held until the next accepted start
- cout_out  output  1  registered final carry-out
- ovf_out  output  1  registered signed overflow
- cla_a  output  4  to slice A
- cla_b  output  4  to slice B
- cla_cin  output  1  to slice Cin
- cla_s  input  4  from slice S
- cla_cout  input  1  from slice Cout

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; idx=0; carry=0.
  - busy=0, done=0, sum_out=0, cout_out=0, ovf_out=0.
  - Operand registers cleared.
- Reset asserted mid-operation aborts the operation immediately; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch a_in, b_in and cin_in into a_reg, b_reg and carry; clear sum_out; idx=0; go to RUN.
- RUN:
  - Combinational slice drive: cla_a=a_reg[4*idx+:4], cla_b=b_reg[4*idx+:4], cla_cin=carry.
  - Each edge: sum_out[4*idx+:4]<=cla_s; carry<=cla_cout; idx<=idx+1.
  - On the edge where idx==NIBBLES-1, go to DONE and register cout_out<=cla_cout.
  - Register ovf_out<=(a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (cla_s[3]!=a_reg[WIDTH-1]), using the effective B.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE unconditionally.
- Latency: if start is sampled at edge E0, done is high during the cycle following edge E_NIBBLES. For WIDTH=16 that is 4 edges after E0.
- busy is high for exactly NIBBLES cycles.
- start while in RUN or DONE is ignored, with no queuing. Operand inputs are don't-care outside the accepting edge.
- cla_a, cla_b and cla_cin are driven 0 outside RUN, so the shared slice sees no toggling.
- The slice is treated as purely combinational: cla_s/cla_cout must settle within one clock of the cla_* change.
- Carry propagates across nibble boundaries via the carry register, so a full WIDTH-bit ripple is handled at the same latency.
- sum_out, cout_out and ovf_out are stable from done until the next accepted start.
- busy and done are registered outputs, glitch-free.

Optional Feature:
- Macro: CLA_NIBBLE_SEQUENCER_SUB_EN.
- Defined:
  - Adds input sub (1 bit), latched with the operands.
  - When sub=1: b_reg latches ~b_in, and carry latches 1 (cin_in is ignored). The result is a_in-b_in in two's complement.
  - cout_out=1 means no borrow.
  - Overflow uses the inverted B MSB.
- Undefined: the sub port is absent; behaviour is addition only.

Test Plan (WIDTH=16):
- a=0x1234, b=0x4321, cin=0, start one cycle -> busy high 4 cycles; done at edge 4; sum_out=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum_out=0x0000, cout=1, ovf=0. Verifies the carry chains through all 4 nibbles; same 4-cycle latency.
- a=0x7FFF, b=0x0001, cin=0 -> sum_out=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum_out=0x0000, cout=1, ovf=1.
- Start a=0x0001, b=0x0001; pulse start again with a=0xAAAA at cycle 2 -> second start ignored; single done; sum_out=0x0002. cla_a/cla_b=0 while IDLE.
- Start a=0x00FF, b=0x0001; drop rst_n at cycle 2 -> busy=0, done never pulses, sum_out=0. After release, a fresh start completes normally.
- (SUB_EN) a=0x0005, b=0x0007, sub=1 -> sum_out=0xFFFE, cout=0. With a=0x8000, b=0x0001, sub=1 -> sum_out=0x7FFF, ovf=1.
